// File: rtl/debounce_multi_if.sv
// Switch bundle for the multi-channel debouncer.
// Raw pins in, debounced level and event pulses out.
interface debounce_multi_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] i_switch;
  logic [N_CH-1:0] o_level;
  logic [N_CH-1:0] o_press;
  logic [N_CH-1:0] o_release;
  logic [N_CH-1:0] o_long;

  modport master (
    output i_switch,
    input  o_level,
    input  o_press,
    input  o_release,
    input  o_long
  );

  modport slave (
    input  i_switch,
    output o_level,
    output o_press,
    output o_release,
    output o_long
  );
endinterface

// File: rtl/debounce_multi.sv
// Per-channel switch debouncer with press, release
// and long-press event pulses.
module debounce_multi #(
  parameter int N_CH             = 4,
  parameter int DEBOUNCE_LIMIT   = 500_000,
  parameter int LONG_PRESS_LIMIT = 100_000_000,
  parameter bit ACTIVE_LEVEL     = 1'b1
) (
  input logic            i_clk,
  input logic            i_reset,
  debounce_multi_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int HW = $clog2(LONG_PRESS_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_LIMIT - 1);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(LONG_PRESS_LIMIT - 1);
  localparam logic [HW-1:0] HOLD_MAX =
    HW'(LONG_PRESS_LIMIT);

  logic [N_CH-1:0] level_v;
  logic [N_CH-1:0] press_v;
  logic [N_CH-1:0] rel_v;
  logic [N_CH-1:0] long_v;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold;
    logic          stable;
    logic          press_q;
    logic          rel_q;
    logic          long_q;
    logic          sample;
    logic          differ;
    logic          flip;

    assign sample = (sync[1] == ACTIVE_LEVEL);
    assign differ = (sample != stable);
    assign flip   = differ && (cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        sync    <= {2{~ACTIVE_LEVEL}};
        cnt     <= '0;
        hold    <= '0;
        stable  <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        sync    <= {sync[0], bus.i_switch[c]};
        press_q <= flip && !stable;
        rel_q   <= flip && stable;
        // a release landing on the long edge wins
        long_q  <= stable && !flip &&
                   (hold == HOLD_LAST);
        if (flip) begin
          stable <= ~stable;
          cnt    <= '0;
        end else if (differ) begin
          cnt <= cnt + 1'b1;
        end else begin
          cnt <= '0;
        end
        if (flip) begin
          hold <= '0;
        end else if (stable && hold != HOLD_MAX) begin
          hold <= hold + 1'b1;
        end
      end
    end

    assign level_v[c] = stable;
    assign press_v[c] = press_q;
    assign rel_v[c]   = rel_q;
    assign long_v[c]  = long_q;
  end

  assign bus.o_level   = level_v;
  assign bus.o_press   = press_v;
  assign bus.o_release = rel_v;
  assign bus.o_long    = long_v;
endmodule
